// File: rtl/clock_pkg.sv
// Shared constants and elaboration helpers for the CPU clock sequencer.
package clock_pkg;

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int unsigned CYCLE_CNT_W = 16;

    // A zero result flags an unusable divider at elaboration.
    function automatic int unsigned calc_div(input int unsigned src, input int unsigned tgt);
        return (tgt == 0) ? 0 : src / tgt;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_sequencer_btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw board input.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            meta       <= raw_in;
            sync       <= meta;
            rise_pulse <= 1'b0;
            // Any sample matching the current level restarts the stability window.
            if (sync == level_out) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_out  <= sync;
                rise_pulse <= sync;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_sequencer.sv
// CPU clock-enable sequencer: reset hold, divided RUN pulses, single STEP pulses, halt.
// Optional cycle_cnt output is built when CLOCK_SEQ_CYCLE_CNT_EN is defined.
module clock_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned SOURCE_CLK        = 100,
    parameter int unsigned TARGET_CLK        = 50,
    parameter int unsigned DEBOUNCE_CYCLES   = 10,
    parameter int unsigned RESET_HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step_btn,
    input  logic mode_sel,
    input  logic halt_req,
    output logic cpu_clk_en,
    output logic cpu_rst_n,
    output logic running,
`ifdef CLOCK_SEQ_CYCLE_CNT_EN
    output logic halted,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt
`else
    output logic halted
`endif
);

    localparam int unsigned DIV = calc_div(SOURCE_CLK, TARGET_CLK);
    localparam int unsigned DW  = cnt_width(DIV);
    localparam int unsigned HW  = cnt_width(RESET_HOLD_CYCLES);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("clock_sequencer: SOURCE_CLK/TARGET_CLK must be at least 1");
        end
        if (DEBOUNCE_CYCLES < 1 || RESET_HOLD_CYCLES < 1) begin : g_bad_cycles
            $error("clock_sequencer: DEBOUNCE_CYCLES and RESET_HOLD_CYCLES must be at least 1");
        end
    endgenerate

    logic step_level;
    logic step_event;
    logic mode_level;
    logic mode_rise;
    logic unused_levels;

    assign unused_levels = step_level ^ mode_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (step_btn),
        .level_out (step_level),
        .rise_pulse(step_event)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (mode_sel),
        .level_out (mode_level),
        .rise_pulse(mode_rise)
    );

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          pulse_next;
    logic          tick;
    logic [DW-1:0] div_cnt;
    logic [HW-1:0] hold_cnt;

    assign tick = (div_cnt == DIV_LAST);

    // Halt is tested first in every active state so it beats ticks, steps and mode changes.
    always_comb begin
        state_next = state;
        pulse_next = 1'b0;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = mode_level ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_HALTED;
                end else if (mode_level) begin
                    state_next = ST_STEP;
                end else begin
                    pulse_next = tick;
                end
            end
            ST_STEP: begin
                if (halt_req) begin
                    state_next = ST_HALTED;
                end else begin
                    pulse_next = step_event;
                    if (!mode_level) begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_HALTED: begin
                if (step_event && !halt_req) begin
                    state_next = mode_level ? ST_STEP : ST_RUN;
                end
            end
            default: state_next = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            div_cnt    <= '0;
            cpu_clk_en <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            state      <= state_next;
            cpu_clk_en <= pulse_next;
            cpu_rst_n  <= (state_next != ST_HOLD);
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            // Divider only advances while RUN persists, so every RUN entry starts from zero.
            if (state == ST_RUN && state_next == ST_RUN) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end
        end
    end

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);

`ifdef CLOCK_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (cpu_clk_en) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_sequencer.sv
// Randomised scoreboard bench for clock_sequencer against a behavioural model.
module tb_clock_sequencer;

    localparam int SRC   = 100;
    localparam int TGT   = 50;
    localparam int DEB   = 10;
    localparam int HOLDC = 4;
    localparam int DIV   = SRC / TGT;

    logic clk = 1'b0;
    logic rst_n;
    logic step_btn;
    logic mode_sel;
    logic halt_req;
    logic cpu_clk_en;
    logic cpu_rst_n;
    logic running;
    logic halted;
`ifdef CLOCK_SEQ_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    always #5 clk = ~clk;

    clock_sequencer #(
        .SOURCE_CLK       (SRC),
        .TARGET_CLK       (TGT),
        .DEBOUNCE_CYCLES  (DEB),
        .RESET_HOLD_CYCLES(HOLDC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_btn  (step_btn),
        .mode_sel  (mode_sel),
        .halt_req  (halt_req),
        .cpu_clk_en(cpu_clk_en),
        .cpu_rst_n (cpu_rst_n),
        .running   (running),
`ifdef CLOCK_SEQ_CYCLE_CNT_EN
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
`else
        .halted    (halted)
`endif
    );

    typedef enum int {M_HOLD, M_RUN, M_STEP, M_HALT} mstate_t;
    typedef struct {
        logic        en;
        logic        rstn;
        logic        run;
        logic        hlt;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Behavioural model state: raw input histories indexed by clock edge since reset release.
    logic    hs[$];
    logic    hm[$];
    int      n;
    logic    lvl_s, lvl_m, evt;
    int      lf_s, lf_m;
    mstate_t st;
    int      held;
    int      entry;
    logic [15:0] cnt_m;
    logic    prev_pulse;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic samp(input bit ch, input int k);
        if (k < 1) return 1'b0;
        return ch ? hm[k-1] : hs[k-1];
    endfunction

    // True when the synchronised input (raw delayed two edges) has disagreed with the
    // debounced level on each of the last DEB edges, all after the previous change.
    function automatic bit settles(input bit ch, input logic level, input int lastf, input int e);
        if (e - DEB < lastf) return 1'b0;
        for (int j = e - DEB + 1; j <= e; j++)
            if (samp(ch, j - 2) == level) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        n = 0; hs.delete(); hm.delete();
        lvl_s = 0; lvl_m = 0; evt = 0; lf_s = 0; lf_m = 0;
        st = M_HOLD; held = 0; entry = 0; cnt_m = '0; prev_pulse = 0;
    endtask

    task automatic model_edge(input logic s, input logic m, input logic h);
        logic pulse;
        exp_t e;
        pulse = 1'b0;
        n++;
        hs.push_back(s);
        hm.push_back(m);
        cnt_m = cnt_m + {15'd0, prev_pulse};
        case (st)
            M_HOLD: begin
                held++;
                if (held == HOLDC) begin st = lvl_m ? M_STEP : M_RUN; entry = n; end
            end
            M_RUN: begin
                if (h) st = M_HALT;
                else if (lvl_m) st = M_STEP;
                else if ((n - entry) % DIV == 0) pulse = 1'b1;
            end
            M_STEP: begin
                if (h) st = M_HALT;
                else begin
                    pulse = evt;
                    if (!lvl_m) begin st = M_RUN; entry = n; end
                end
            end
            M_HALT: begin
                if (evt && !h) begin st = lvl_m ? M_STEP : M_RUN; entry = n; end
            end
            default: st = M_HOLD;
        endcase
        evt = 1'b0;
        if (settles(1'b0, lvl_s, lf_s, n)) begin lvl_s = ~lvl_s; lf_s = n; evt = lvl_s; end
        if (settles(1'b1, lvl_m, lf_m, n)) begin lvl_m = ~lvl_m; lf_m = n; end
        prev_pulse = pulse;
        e.en = pulse; e.rstn = (st != M_HOLD); e.run = (st == M_RUN);
        e.hlt = (st == M_HALT); e.cnt = cnt_m;
        sb.push_back(e);
    endtask

    // Drives one cycle's inputs at a falling edge and records the model's prediction.
    task automatic cyc(input logic s, input logic m, input logic h);
        step_btn = s; mode_sel = m; halt_req = h;
        model_edge(s, m, h);
        @(negedge clk);
    endtask

    task automatic hold_inputs(input logic s, input logic m, input logic h, input int k);
        for (int i = 0; i < k; i++) cyc(s, m, h);
    endtask

    task automatic bounce(input logic m, input logic h, input int a, input int b, input int c,
                          input int d, input int stable, input logic start);
        hold_inputs(start, m, h, a);
        hold_inputs(~start, m, h, b);
        hold_inputs(start, m, h, c);
        hold_inputs(~start, m, h, d);
        hold_inputs(start, m, h, stable);
    endtask

    task automatic check_reset_outputs();
        check("rst_clk_en", {15'd0, cpu_clk_en}, 16'd0);
        check("rst_cpu_rst_n", {15'd0, cpu_rst_n}, 16'd0);
        check("rst_running", {15'd0, running}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
`ifdef CLOCK_SEQ_CYCLE_CNT_EN
        check("rst_cycle_cnt", cycle_cnt, 16'd0);
`endif
    endtask

    // Monitor: pops the scoreboard one edge at a time, sampling just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cpu_clk_en", {15'd0, cpu_clk_en}, {15'd0, e.en});
                check("cpu_rst_n", {15'd0, cpu_rst_n}, {15'd0, e.rstn});
                check("running", {15'd0, running}, {15'd0, e.run});
                check("halted", {15'd0, halted}, {15'd0, e.hlt});
`ifdef CLOCK_SEQ_CYCLE_CNT_EN
                check("cycle_cnt", cycle_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic cs, cm, ch;
        int   ss, sm, sh;
        rst_n = 1'b0; step_btn = 1'b0; mode_sel = 1'b0; halt_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();

        // Power-up in RUN, then a halt request, then a step press to leave HALTED.
        rst_n = 1'b1;
        hold_inputs(1'b0, 1'b0, 1'b0, 25 + $urandom_range(0, 3));
        hold_inputs(1'b0, 1'b0, 1'b1, 3);
        hold_inputs(1'b0, 1'b0, 1'b0, 5);
        hold_inputs(1'b1, 1'b0, 1'b0, 20);
        hold_inputs(1'b0, 1'b0, 1'b0, 20);

        // Settle into STEP, clean press, then the bouncy press/release pattern.
        hold_inputs(1'b0, 1'b1, 1'b0, 20);
        hold_inputs(1'b1, 1'b1, 1'b0, 20);
        hold_inputs(1'b0, 1'b1, 1'b0, 20);
        bounce(1'b1, 1'b0, 1, 2, 2, 4, 11, 1'b1);
        bounce(1'b1, 1'b0, 2, 2, 3, 1, 13, 1'b0);

        // Halt from STEP; a press while halted is ignored, a later press resumes STEP.
        hold_inputs(1'b0, 1'b1, 1'b1, 4);
        hold_inputs(1'b1, 1'b1, 1'b1, 20);
        hold_inputs(1'b0, 1'b1, 1'b1, 20);
        hold_inputs(1'b0, 1'b1, 1'b0, 4);
        hold_inputs(1'b1, 1'b1, 1'b0, 20);
        hold_inputs(1'b0, 1'b1, 1'b0, 20);
        hold_inputs(1'b0, 1'b0, 1'b0, 30);

        // Random spans of step, mode and halt activity.
        cs = 0; cm = 0; ch = 0; ss = 1; sm = 40; sh = 30;
        for (int i = 0; i < 1500; i++) begin
            if (--ss == 0) begin cs = ~cs; ss = $urandom_range(1, 24); end
            if (--sm == 0) begin cm = ~cm; sm = $urandom_range(20, 150); end
            if (--sh == 0) begin ch = ~ch; sh = ch ? $urandom_range(1, 6) : $urandom_range(10, 80); end
            cyc(cs, cm, ch);
        end

        // Asynchronous reset mid-RUN, then the power-up sequence again.
        hold_inputs(1'b0, 1'b0, 1'b0, 60 + $urandom_range(0, 3));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (4) @(negedge clk);
        check_reset_outputs();
        model_reset();
        rst_n = 1'b1;
        hold_inputs(1'b0, 1'b0, 1'b0, 40);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
